regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between the ALU and load/memory writeback paths.
//  - Each source has a 1-entry hold buffer; at most one write per cycle, oldest entry first.
//  - Drives reg_we/w_addr/w_data of register_file.
//  - Reports pending writes per read address so decode can stall on a hazard.
// PARAMETERS
//  DATA_W   32  writeback data width
//  ADDR_W   5   register address width (32 registers; x0 hard-wired zero)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst_n         in   1       asynchronous reset, active-low
//  alu_valid     in   1       ALU writeback request
//  alu_addr      in   ADDR_W  ALU destination register
//  alu_data      in   DATA_W  ALU result
//  alu_ready     out  1       ALU request accepted this cycle when alu_valid & alu_ready
//  mem_valid     in   1       load writeback request
//  mem_addr      in   ADDR_W  load destination register
//  mem_data      in   DATA_W  load data
//  mem_ready     out  1       load request accepted this cycle when mem_valid & mem_ready
//  rf_we         out  1       register-file write enable (`ENABLE polarity)
//  rf_w_addr     out  ADDR_W  register-file write address
//  rf_w_data     out  DATA_W  register-file write data
//  rs1_addr      in   ADDR_W  decode read address 1
//  rs2_addr      in   ADDR_W  decode read address 2
//  rs1_pending   out  1       a held write targets rs1_addr (never for x0)
//  rs2_pending   out  1       a held write targets rs2_addr (never for x0)
// BEHAVIOUR
//  - State: hold_alu{v,addr,data}, hold_mem{v,addr,data}, alu_older (1 = ALU hold arrived first).
//  - Reset (rst_n low, async): both holds invalid, alu_older=0.
//    rf_we=0, rf_w_addr=0, rf_w_data=0, pending=0, alu_ready=mem_ready=0 while rst_n low.
//  - Grant (combinational from state only): only one hold valid -> that one.
//    Both valid -> alu_older ? ALU : MEM.
//  - rf_we = grant exists; rf_w_addr/rf_w_data = granted hold; all zero when no grant.
//    The write lands in register_file at the next edge.
//  - x_ready = ~hold_x.v | grant_x. No path from x_valid to x_ready.
//    Sustained 1 write/cycle from a lone source.
//  - Accept (x_valid & x_ready): addr != 0 -> load hold_x at the edge (replaces a granted entry);
//    addr == 0 -> accepted and discarded, hold_x invalid, no rf_we ever.
//  - Latency: accept at edge N -> rf_we high in cycle N..N+1 if uncontended -> RF updated at edge N+1.
//  - Age: new entry loaded while the other hold stays valid and ungranted -> new entry is younger.
//    Both load at the same edge -> MEM older (alu_older=0).
//    Entry loaded while the other hold is granted/empty -> the new entry is oldest.
//  - Same addr in both holds: written oldest-first, so the younger value survives in the RF.
//  - No starvation: a loser becomes the oldest and wins next cycle; max wait 1 cycle.
//  - rsN_pending = (rsN_addr!=0) & ((hold_alu.v & hold_alu.addr==rsN_addr) | (hold_mem.v & same)).
//    Includes the entry being written this cycle.
//  - Reset mid-operation: held writes are dropped, never written.
// CONFIGURATION
//  WB_BYPASS_EN defined: adds outputs rs1_fwd_valid, rs2_fwd_valid (1) and rs1_fwd_data, rs2_fwd_data (DATA_W).
//    fwd_valid = pending; fwd_data = data of the youngest matching hold, 0 when no match.
//    Decode forwards instead of stalling. Outputs are 0 in reset.
//  WB_BYPASS_EN undefined: these ports are absent; pending outputs only.
// TESTING
//  - Reset: rst_n=0 with alu_valid=1 -> rf_we=0, alu_ready=0. Release -> alu_ready=1, no write.
//  - Lone ALU, addr 3/4/5 data 0xA/0xB/0xC back-to-back -> rf_we 3 consecutive cycles, x3=0xA, x4=0xB, x5=0xC.
//  - Same-cycle ALU x7=0x11 and MEM x7=0x22 -> cycle 1 writes x7=0x22 (MEM).
//    Cycle 2 writes x7=0x11; mem_ready=1 and alu_ready=0 in cycle 1.
//  - MEM x9=0x5 stalled in hold while new ALU x9=0x6 arrives -> order is 0x5 then 0x6.
//    rs1_addr=9 -> rs1_pending=1 until the last write, then 0.
//  - alu_addr=0, data=0xFFFF -> accepted, rf_we stays 0, rs1_addr=0 -> rs1_pending=0.
//  - WB_BYPASS_EN with both holds on x12 (MEM older 0x1, ALU 0x2) -> rs2_fwd_data=0x2.
//    Reset asserted mid-hold -> no further rf_we.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources (ALU and load/MEM) each have a 1-entry hold buffer.
// At most one hold is written per cycle, oldest first, and the loser becomes
// the oldest, so it waits at most one cycle. Pending-write flags per decode
// read address let decode detect a RAW hazard on a write still in flight.
// Optional feature macro: WB_BYPASS_EN adds forwarding outputs
// (rsN_fwd_valid / rsN_fwd_data) carrying the youngest matching held value.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
`ifdef WB_BYPASS_EN
  output logic              rs1_fwd_valid,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic [DATA_W-1:0] rs2_fwd_data,
`endif
  output logic              rs1_pending,
  output logic              rs2_pending
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } hold_t;

  hold_t h_alu, h_mem;
  logic  alu_older, older_nxt;
  logic  grant_alu, grant_mem;
  logic  acc_alu, acc_mem, load_alu, load_mem;

  // Grant depends on held state only; a lone hold wins, otherwise the older one.
  always_comb begin
    grant_alu = h_alu.v & (~h_mem.v | alu_older);
    grant_mem = h_mem.v & (~h_alu.v | ~alu_older);
  end

  // A hold can take a new entry when empty or when it is draining this cycle.
  // Held low through reset so nothing is accepted while rst_n is asserted.
  assign alu_ready = rst_n & (~h_alu.v | grant_alu);
  assign mem_ready = rst_n & (~h_mem.v | grant_mem);

  assign acc_alu  = alu_valid & alu_ready;
  assign acc_mem  = mem_valid & mem_ready;
  // Writes to x0 are accepted and dropped; they never occupy a hold.
  assign load_alu = acc_alu & (alu_addr != '0);
  assign load_mem = acc_mem & (mem_addr != '0);

  // ALU hold: load on accept, otherwise clear once its write is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_alu <= '0;
    end else if (acc_alu) begin
      h_alu.v    <= load_alu;
      h_alu.addr <= alu_addr;
      h_alu.data <= alu_data;
    end else if (grant_alu) begin
      h_alu.v <= 1'b0;
    end
  end

  // MEM hold: same policy as the ALU hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_mem <= '0;
    end else if (acc_mem) begin
      h_mem.v    <= load_mem;
      h_mem.addr <= mem_addr;
      h_mem.data <= mem_data;
    end else if (grant_mem) begin
      h_mem.v <= 1'b0;
    end
  end

  // Age tracking: a new entry is younger only if the other hold stays valid
  // and ungranted across the edge; simultaneous loads make MEM the older.
  always_comb begin
    older_nxt = alu_older;
    if (load_alu && load_mem)
      older_nxt = 1'b0;
    else if (load_alu)
      older_nxt = ~(h_mem.v & ~grant_mem);
    else if (load_mem)
      older_nxt = h_alu.v & ~grant_alu;
  end

  // Age bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_older <= 1'b0;
    else        alu_older <= older_nxt;
  end

  // Register-file write port driven from the granted hold, zero when idle.
  always_comb begin
    rf_we     = grant_alu | grant_mem;
    rf_w_addr = '0;
    rf_w_data = '0;
    if (grant_alu) begin
      rf_w_addr = h_alu.addr;
      rf_w_data = h_alu.data;
    end else if (grant_mem) begin
      rf_w_addr = h_mem.addr;
      rf_w_data = h_mem.data;
    end
  end

  logic m1_alu, m1_mem, m2_alu, m2_mem;

  // Hazard match per read port; x0 never matches. Includes the entry being
  // written this cycle since the RF only sees it at the next edge.
  always_comb begin
    m1_alu = (rs1_addr != '0) & h_alu.v & (h_alu.addr == rs1_addr);
    m1_mem = (rs1_addr != '0) & h_mem.v & (h_mem.addr == rs1_addr);
    m2_alu = (rs2_addr != '0) & h_alu.v & (h_alu.addr == rs2_addr);
    m2_mem = (rs2_addr != '0) & h_mem.v & (h_mem.addr == rs2_addr);
  end

  assign rs1_pending = m1_alu | m1_mem;
  assign rs2_pending = m2_alu | m2_mem;

`ifdef WB_BYPASS_EN
  // Forward the youngest matching held value; when both match, the younger
  // is the one that is not the older.
  always_comb begin
    rs1_fwd_data = '0;
    rs2_fwd_data = '0;
    if (m1_alu && m1_mem) rs1_fwd_data = alu_older ? h_mem.data : h_alu.data;
    else if (m1_alu)      rs1_fwd_data = h_alu.data;
    else if (m1_mem)      rs1_fwd_data = h_mem.data;
    if (m2_alu && m2_mem) rs2_fwd_data = alu_older ? h_mem.data : h_alu.data;
    else if (m2_alu)      rs2_fwd_data = h_alu.data;
    else if (m2_mem)      rs2_fwd_data = h_mem.data;
  end

  assign rs1_fwd_valid = rs1_pending;
  assign rs2_fwd_valid = rs2_pending;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected values are hand-computed.
// With WB_BYPASS_EN defined the forwarding outputs are exercised as well.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, mem_valid;
  logic [ADDR_W-1:0] alu_addr, mem_addr, rs1_addr, rs2_addr;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready, rf_we;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic              rs1_pending, rs2_pending;
`ifdef WB_BYPASS_EN
  logic              rs1_fwd_valid, rs2_fwd_valid;
  logic [DATA_W-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int checks = 0;
  int passed = 0;

  logic [DATA_W-1:0] shadow [32] = '{default: '0};

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
`ifdef WB_BYPASS_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending)
  );

  always #5 clk = ~clk;

  // Register-file model: captures what the arbiter actually writes.
  always @(posedge clk) if (rf_we === 1'b1) shadow[rf_w_addr] <= rf_w_data;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h99;
    #12;
    checks++; if (rf_we !== 1'b0) $display("FAIL rst_we got=%0h exp=0", rf_we); else passed++;
    checks++; if (alu_ready !== 1'b0) $display("FAIL rst_alu_ready got=%0h exp=0", alu_ready); else passed++;
    checks++; if (mem_ready !== 1'b0) $display("FAIL rst_mem_ready got=%0h exp=0", mem_ready); else passed++;
    tick();
    checks++; if (rf_w_addr !== 5'd0 || rf_w_data !== 32'd0) $display("FAIL rst_wdata got=%0h/%0h exp=0/0", rf_w_addr, rf_w_data); else passed++;
    idle();
    rst_n = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b1) $display("FAIL rel_alu_ready got=%0h exp=1", alu_ready); else passed++;
    checks++; if (mem_ready !== 1'b1) $display("FAIL rel_mem_ready got=%0h exp=1", mem_ready); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL rel_we got=%0h exp=0", rf_we); else passed++;
  endtask

  task automatic test_lone_alu();
    logic [ADDR_W-1:0] ea [3];
    logic [DATA_W-1:0] ed [3];
    ea = '{5'd3, 5'd4, 5'd5};
    ed = '{32'hA, 32'hB, 32'hC};
    alu_valid = 1'b1; alu_addr = ea[0]; alu_data = ed[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_w_addr !== ea[i] || rf_w_data !== ed[i] || alu_ready !== 1'b1)
        $display("FAIL lone_wr%0d got we=%0h a=%0d d=%0h rdy=%0h exp we=1 a=%0d d=%0h rdy=1",
                 i, rf_we, rf_w_addr, rf_w_data, alu_ready, ea[i], ed[i]);
      else passed++;
      if (i < 2) begin alu_addr = ea[i+1]; alu_data = ed[i+1]; end
      else idle();
    end
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL lone_idle got=%0h exp=0", rf_we); else passed++;
    checks++;
    if (shadow[3] !== 32'hA || shadow[4] !== 32'hB || shadow[5] !== 32'hC)
      $display("FAIL lone_rf got=%0h/%0h/%0h exp=a/b/c", shadow[3], shadow[4], shadow[5]);
    else passed++;
  endtask

  task automatic test_same_cycle();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h22;
    tick();
    idle();
    checks++; if (rf_we !== 1'b1 || rf_w_addr !== 5'd7 || rf_w_data !== 32'h22) $display("FAIL same_c1 got we=%0h a=%0d d=%0h exp 1/7/22", rf_we, rf_w_addr, rf_w_data); else passed++;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) $display("FAIL same_rdy got mem=%0h alu=%0h exp 1/0", mem_ready, alu_ready); else passed++;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_w_addr !== 5'd7 || rf_w_data !== 32'h11) $display("FAIL same_c2 got we=%0h a=%0d d=%0h exp 1/7/11", rf_we, rf_w_addr, rf_w_data); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL same_idle got=%0h exp=0", rf_we); else passed++;
    checks++; if (shadow[7] !== 32'h11) $display("FAIL same_rf got=%0h exp=11", shadow[7]); else passed++;
  endtask

  task automatic test_age();
    rs1_addr = 5'd9;
    alu_valid = 1'b1; alu_addr = 5'd8;  alu_data = 32'h1;
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h2;
    tick();
    checks++; if (rf_w_addr !== 5'd10 || rf_w_data !== 32'h2 || alu_ready !== 1'b0) $display("FAIL age_c1 got a=%0d d=%0h ardy=%0h exp 10/2/0", rf_w_addr, rf_w_data, alu_ready); else passed++;
    alu_valid = 1'b0; mem_addr = 5'd9; mem_data = 32'h5;
    tick();
    mem_valid = 1'b0;
    checks++; if (rf_w_addr !== 5'd8 || rf_w_data !== 32'h1 || mem_ready !== 1'b0 || alu_ready !== 1'b1) $display("FAIL age_c2 got a=%0d d=%0h mrdy=%0h ardy=%0h exp 8/1/0/1", rf_w_addr, rf_w_data, mem_ready, alu_ready); else passed++;
    checks++; if (rs1_pending !== 1'b1) $display("FAIL age_pend2 got=%0h exp=1", rs1_pending); else passed++;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h6;
    tick();
    idle();
    checks++; if (rf_we !== 1'b1 || rf_w_addr !== 5'd9 || rf_w_data !== 32'h5 || rs1_pending !== 1'b1) $display("FAIL age_c3 got we=%0h a=%0d d=%0h p=%0h exp 1/9/5/1", rf_we, rf_w_addr, rf_w_data, rs1_pending); else passed++;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_w_addr !== 5'd9 || rf_w_data !== 32'h6 || rs1_pending !== 1'b1) $display("FAIL age_c4 got we=%0h a=%0d d=%0h p=%0h exp 1/9/6/1", rf_we, rf_w_addr, rf_w_data, rs1_pending); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0 || rs1_pending !== 1'b0) $display("FAIL age_c5 got we=%0h p=%0h exp 0/0", rf_we, rs1_pending); else passed++;
    checks++; if (shadow[9] !== 32'h6) $display("FAIL age_rf got=%0h exp=6", shadow[9]); else passed++;
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF; rs1_addr = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b1) $display("FAIL x0_rdy got=%0h exp=1", alu_ready); else passed++;
    tick();
    idle();
    checks++; if (rf_we !== 1'b0 || rs1_pending !== 1'b0 || alu_ready !== 1'b1) $display("FAIL x0_c1 got we=%0h p=%0h rdy=%0h exp 0/0/1", rf_we, rs1_pending, alu_ready); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL x0_c2 got=%0h exp=0", rf_we); else passed++;
  endtask

  task automatic test_reset_mid();
    rs1_addr = 5'd14; rs2_addr = 5'd12;
`ifdef WB_BYPASS_EN
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h2;
    mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h1;
    tick();
    idle();
    checks++; if (rs2_fwd_valid !== 1'b1 || rs2_fwd_data !== 32'h2) $display("FAIL byp_young got v=%0h d=%0h exp 1/2", rs2_fwd_valid, rs2_fwd_data); else passed++;
    checks++; if (rs1_fwd_valid !== 1'b0 || rs1_fwd_data !== 32'h0) $display("FAIL byp_nomatch got v=%0h d=%0h exp 0/0", rs1_fwd_valid, rs1_fwd_data); else passed++;
    checks++; if (rf_w_data !== 32'h1) $display("FAIL byp_order got=%0h exp=1", rf_w_data); else passed++;
    tick();
`endif
    alu_valid = 1'b1; alu_addr = 5'd14; alu_data = 32'h3;
    mem_valid = 1'b1; mem_addr = 5'd15; mem_data = 32'h4;
    tick();
    idle();
    checks++; if (rf_we !== 1'b1 || rf_w_addr !== 5'd15 || rs1_pending !== 1'b1) $display("FAIL rmid_pre got we=%0h a=%0d p=%0h exp 1/15/1", rf_we, rf_w_addr, rs1_pending); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || rs1_pending !== 1'b0) $display("FAIL rmid_in got we=%0h p=%0h exp 0/0", rf_we, rs1_pending); else passed++;
`ifdef WB_BYPASS_EN
    checks++; if (rs1_fwd_valid !== 1'b0 || rs1_fwd_data !== 32'h0) $display("FAIL rmid_fwd got v=%0h d=%0h exp 0/0", rs1_fwd_valid, rs1_fwd_data); else passed++;
`endif
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL rmid_post1 got=%0h exp=0", rf_we); else passed++;
    tick();
    checks++; if (rf_we !== 1'b0) $display("FAIL rmid_post2 got=%0h exp=0", rf_we); else passed++;
    checks++; if (shadow[14] !== 32'h0 || shadow[15] !== 32'h0) $display("FAIL rmid_rf got=%0h/%0h exp=0/0", shadow[14], shadow[15]); else passed++;
  endtask

  initial begin
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    test_reset();
    test_lone_alu();
    test_same_cycle();
    test_age();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
